// File: rtl/rom_arb_pkg.sv
// ROM load arbiter shared definitions.
// Holds the arbiter state encoding, the RAM read latency and the default
// address width / core-reset hold length used by rom_load_arbiter.
package rom_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WRITE    = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_RD_DONE  = 3'd4
    } arb_state_t;

    // Cycles from driving mem_addr to mem_rdata being capturable (ISSUE + WAIT).
    localparam int READ_LATENCY        = 2;
    localparam int DEFAULT_AW          = 16;
    localparam int DEFAULT_HOLD_CYCLES = 16;
    localparam int DL_ADDR_W           = 25;

endpackage

// File: rtl/rst_hold_timer.sv
// Core reset hold timer.
// core_reset is high while dl_active is high and for HOLD_CYCLES clk_sys
// cycles after it falls; a new rise during the hold restarts the count.
// Also provides a one-cycle dl_rise indication of a dl_active rising edge.
// Ports:
//   clk_sys    in   clock
//   reset_n    in   async active-low reset (counter reloads, core_reset high)
//   dl_active  in   download in progress
//   core_reset out  reset to the game core
//   dl_rise    out  dl_active rising edge (valid in the cycle it rises)
module rst_hold_timer
    import rom_arb_pkg::*;
#(
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic dl_active,
    output logic core_reset,
    output logic dl_rise
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_VAL = CW'(HOLD_CYCLES);

    logic [CW-1:0] hold_cnt;
    logic          dl_active_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt    <= HOLD_VAL;
            dl_active_q <= 1'b0;
        end else begin
            dl_active_q <= dl_active;
            if (dl_active) begin
                hold_cnt <= HOLD_VAL;
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - CW'(1);
            end
        end
    end

    // dl_active is ORed in directly so the core sees reset in the same cycle
    // the download starts, not one cycle later.
    assign core_reset = dl_active | (hold_cnt != '0);
    assign dl_rise    = dl_active & ~dl_active_q;

endmodule

// File: rtl/rom_load_arbiter.sv
// ROM load arbiter.
// Shares one single-port synchronous RAM between the ROM download port
// (through a one-entry write buffer) and two CPU read ports (round-robin),
// and generates the game core reset around downloads.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | waiting; buffered write wins over reads
// ST_WRITE    | mem_we high one cycle with the buffered byte
// ST_RD_ISSUE | mem_addr driven with the granted read address
// ST_RD_WAIT  | waiting for RAM read data
// ST_RD_DONE  | rd_data valid, rdy pulse to the granted requester
//
// Ports:
//   clk_sys, reset_n          clock, async active-low reset
//   dl_active/dl_wr/dl_addr/dl_data   ROM download stream
//   req_a/addr_a, req_b/addr_b        read requests (main CPU / sound CPU)
//   rdy_a, rdy_b, rd_data             read completion and data
//   mem_addr/mem_we/mem_wdata/mem_rdata  RAM port
//   core_reset                reset to the game core
//   dl_overflow               sticky, a download byte was lost
module rom_load_arbiter
    import rom_arb_pkg::*;
#(
    parameter int AW          = DEFAULT_AW,
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 dl_active,
    input  logic                 dl_wr,
    input  logic [DL_ADDR_W-1:0] dl_addr,
    input  logic [7:0]           dl_data,
    input  logic                 req_a,
    input  logic                 req_b,
    input  logic [AW-1:0]        addr_a,
    input  logic [AW-1:0]        addr_b,
    output logic                 rdy_a,
    output logic                 rdy_b,
    output logic [7:0]           rd_data,
    output logic [AW-1:0]        mem_addr,
    output logic                 mem_we,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata,
    output logic                 core_reset,
    output logic                 dl_overflow
);

    localparam int WAIT_CYCLES = READ_LATENCY - 1;
    localparam int LW          = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [LW-1:0] LAT_LOAD = LW'(WAIT_CYCLES - 1);

    arb_state_t state, state_nxt;

    logic          buf_valid;
    logic [AW-1:0] buf_addr;
    logic [7:0]    buf_data;
    logic          rr_b;
    logic          gnt_b;
    logic [LW-1:0] lat_cnt;
    logic          dl_rise;

    logic dl_in_range;
    logic buf_drain;
    logic buf_load;
    logic ovf_set;
    logic rd_ok;
    logic pick_b;

    rst_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_rst_hold_timer (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .dl_active (dl_active),
        .core_reset(core_reset),
        .dl_rise   (dl_rise)
    );

    // Bytes beyond the RAM are dropped without flagging overflow.
    assign dl_in_range = ((dl_addr >> AW) == '0);
    // The buffer empties in WRITE, so a byte arriving then is not a collision.
    assign buf_drain   = (state == ST_WRITE);
    assign buf_load    = dl_wr & dl_in_range & (~buf_valid | buf_drain);
    assign ovf_set     = dl_wr & dl_in_range & buf_valid & ~buf_drain;
    assign rd_ok       = ~dl_active & ~core_reset;
    // rr_b only matters when both request; a lone requester always wins.
    assign pick_b      = req_b & (~req_a | rr_b);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (buf_valid) begin
                    state_nxt = ST_WRITE;
                end else if (rd_ok && (req_a || req_b)) begin
                    state_nxt = ST_RD_ISSUE;
                end
            end
            ST_WRITE:    state_nxt = ST_IDLE;
            ST_RD_ISSUE: state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (lat_cnt == '0) begin
                    state_nxt = ST_RD_DONE;
                end
            end
            ST_RD_DONE:  state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_we = 1'b0;
        rdy_a  = 1'b0;
        rdy_b  = 1'b0;
        case (state)
            ST_WRITE: mem_we = 1'b1;
            ST_RD_DONE: begin
                rdy_a = ~gnt_b;
                rdy_b = gnt_b;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            buf_valid   <= 1'b0;
            buf_addr    <= '0;
            buf_data    <= '0;
            dl_overflow <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rd_data     <= '0;
            rr_b        <= 1'b0;
            gnt_b       <= 1'b0;
            lat_cnt     <= '0;
        end else begin
            if (buf_load) begin
                buf_valid <= 1'b1;
                buf_addr  <= dl_addr[AW-1:0];
                buf_data  <= dl_data;
            end else if (buf_drain) begin
                buf_valid <= 1'b0;
            end

            // A loss in the same cycle as a new download start still counts.
            if (ovf_set) begin
                dl_overflow <= 1'b1;
            end else if (dl_rise) begin
                dl_overflow <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (state_nxt == ST_WRITE) begin
                        mem_addr  <= buf_addr;
                        mem_wdata <= buf_data;
                    end else if (state_nxt == ST_RD_ISSUE) begin
                        gnt_b    <= pick_b;
                        mem_addr <= pick_b ? addr_b : addr_a;
                        if (req_a && req_b) begin
                            rr_b <= ~rr_b;
                        end
                    end
                end
                ST_RD_ISSUE: lat_cnt <= LAT_LOAD;
                ST_RD_WAIT: begin
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - LW'(1);
                    end else begin
                        rd_data <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_load_arbiter.sv
module tb_rom_load_arbiter;

    logic        clk_sys;
    logic        reset_n;
    logic        dl_active;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        req_a;
    logic        req_b;
    logic [15:0] addr_a;
    logic [15:0] addr_b;
    logic        rdy_a;
    logic        rdy_b;
    logic [7:0]  rd_data;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        core_reset;
    logic        dl_overflow;

    rom_load_arbiter #(
        .AW(16),
        .HOLD_CYCLES(16)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .dl_active  (dl_active),
        .dl_wr      (dl_wr),
        .dl_addr    (dl_addr),
        .dl_data    (dl_data),
        .req_a      (req_a),
        .req_b      (req_b),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .rdy_a      (rdy_a),
        .rdy_b      (rdy_b),
        .rd_data    (rd_data),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .core_reset (core_reset),
        .dl_overflow(dl_overflow)
    );

    typedef struct {
        bit         is_b;
        logic [7:0] data;
        int         cyc;
    } rd_exp_t;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_exp_t;

    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];
    rd_exp_t re;
    wr_exp_t we;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] mem [0:65535];

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    always @(posedge clk_sys) cyc <= cyc + 1;

    // RAM model: registered read data, valid the cycle after the address.
    always @(posedge clk_sys) begin
        mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: pops whenever the DUT completes a read or writes RAM.
    always @(negedge clk_sys) begin
        if (rdy_a || rdy_b) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rdy: rdy_a=%0b rdy_b=%0b, expected no read completion (cycle %0d)",
                         rdy_a, rdy_b, cyc);
            end else begin
                re = rd_q.pop_front();
                chk("rdy_port", {30'd0, rdy_b, rdy_a}, re.is_b ? 32'd2 : 32'd1);
                chk("rd_data", {24'd0, rd_data}, {24'd0, re.data});
                chk("rdy_cycle", cyc, re.cyc);
            end
        end
        if (mem_we) begin
            if (wr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write (cycle %0d)",
                         mem_addr, mem_wdata, cyc);
            end else begin
                we = wr_q.pop_front();
                chk("wr_addr", {16'd0, mem_addr}, {16'd0, we.addr});
                chk("wr_data", {24'd0, mem_wdata}, {24'd0, we.data});
                chk("wr_cycle", cyc, we.cyc);
            end
        end
    end

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic wait_until_cyc(input int n);
        while (cyc < n) @(negedge clk_sys);
    endtask

    // One read from an idle arbiter: rdy expected 3 cycles after req is raised.
    task automatic do_read(input bit is_b, input logic [15:0] a, input logic [7:0] d);
        bit got;
        tick();
        if (is_b) begin req_b = 1'b1; addr_b = a; end
        else begin req_a = 1'b1; addr_a = a; end
        rd_q.push_back('{is_b, d, cyc + 3});
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (is_b ? rdy_b : rdy_a) begin
                got = 1'b1;
                break;
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL read_timeout: no rdy for addr 0x%0h within 20 cycles", a);
        end
    endtask

    // One download byte; an in-range byte reaches mem_we 2 cycles later.
    task automatic dl_byte(input logic [24:0] a, input logic [7:0] d, input bit exp_wr);
        tick();
        dl_wr   = 1'b1;
        dl_addr = a;
        dl_data = d;
        if (exp_wr) wr_q.push_back('{a[15:0], d, cyc + 2});
        tick();
        dl_wr = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int f;
        int g;
        int r;
        int nrdy;
        bit done;

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0040] = 8'h5C;
        mem[16'h1234] = 8'h3E;
        mem[16'h0100] = 8'hA1;
        mem[16'h0200] = 8'hB2;

        reset_n   = 1'b0;
        dl_active = 1'b0;
        dl_wr     = 1'b0;
        dl_addr   = '0;
        dl_data   = '0;
        req_a     = 1'b0;
        req_b     = 1'b0;
        addr_a    = '0;
        addr_b    = '0;

        // Reset values
        repeat (3) tick();
        chk("rst_rdy_a", rdy_a, 0);
        chk("rst_rdy_b", rdy_b, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_dl_overflow", dl_overflow, 0);
        chk("rst_core_reset", core_reset, 1);

        // core_reset falls 16 cycles after reset release
        reset_n = 1'b1;
        r = cyc;
        wait_until_cyc(r + 15);
        chk("rel_core_reset_hold", core_reset, 1);
        tick();
        chk("rel_core_reset_fall", core_reset, 0);

        // Single reads on each port
        do_read(1'b0, 16'h0040, 8'h5C);
        do_read(1'b1, 16'h1234, 8'h3E);

        // Download: in-range, out-of-range (dropped), top address
        tick();
        dl_active = 1'b1;
        dl_byte(25'h0000123, 8'hA5, 1'b1);
        dl_byte(25'h0010000, 8'h77, 1'b0);
        dl_byte(25'h000FFFF, 8'h11, 1'b1);
        chk("dl_no_overflow", dl_overflow, 0);

        // Read requested during the hold is only granted once core_reset drops
        tick();
        dl_active = 1'b0;
        f = cyc;
        tick();
        tick();
        req_a  = 1'b1;
        addr_a = 16'h0123;
        rd_q.push_back('{1'b0, 8'hA5, f + 19});
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (cyc == f + 15) chk("dl_core_reset_hold", core_reset, 1);
            if (cyc == f + 16) chk("dl_core_reset_fall", core_reset, 0);
            if (rdy_a) begin
                done = 1'b1;
                break;
            end
        end
        req_a = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL gated_read_timeout: no rdy_a within 40 cycles");
        end
        do_read(1'b1, 16'hFFFF, 8'h11);
        do_read(1'b0, 16'h0000, 8'h00);

        // Both requesting continuously: a, b, a, b every 4 cycles
        tick();
        tick();
        c = cyc;
        req_a  = 1'b1;
        addr_a = 16'h0100;
        req_b  = 1'b1;
        addr_b = 16'h0200;
        rd_q.push_back('{1'b0, 8'hA1, c + 3});
        rd_q.push_back('{1'b1, 8'hB2, c + 7});
        rd_q.push_back('{1'b0, 8'hA1, c + 11});
        rd_q.push_back('{1'b1, 8'hB2, c + 15});
        nrdy = 0;
        for (int i = 0; i < 40 && nrdy < 4; i++) begin
            tick();
            if (rdy_a || rdy_b) nrdy++;
        end
        req_a = 1'b0;
        req_b = 1'b0;
        chk("rr_rdy_count", nrdy, 4);

        // Download bytes on consecutive cycles during a read: second is lost
        tick();
        tick();
        c = cyc;
        req_a  = 1'b1;
        addr_a = 16'h0040;
        rd_q.push_back('{1'b0, 8'h5C, c + 3});
        tick();
        dl_active = 1'b1;
        tick();
        dl_wr   = 1'b1;
        dl_addr = 25'h0000300;
        dl_data = 8'hC3;
        wr_q.push_back('{16'h0300, 8'hC3, c + 5});
        tick();
        dl_addr = 25'h0000301;
        dl_data = 8'hD4;
        req_a   = 1'b0;
        tick();
        dl_wr = 1'b0;
        chk("ovf_set", dl_overflow, 1);
        repeat (4) tick();
        chk("ovf_sticky", dl_overflow, 1);

        // Restart of the hold by a second dl_active pulse; rise clears overflow
        tick();
        dl_active = 1'b0;
        f = cyc;
        wait_until_cyc(f + 5);
        chk("ovf_before_rise", dl_overflow, 1);
        dl_active = 1'b1;
        tick();
        chk("ovf_cleared_by_rise", dl_overflow, 0);
        tick();
        dl_active = 1'b0;
        g = cyc;
        wait_until_cyc(f + 16);
        chk("restart_hold_past_first", core_reset, 1);
        wait_until_cyc(g + 15);
        chk("restart_hold_end", core_reset, 1);
        tick();
        chk("restart_hold_fall", core_reset, 0);

        do_read(1'b0, 16'h0300, 8'hC3);
        do_read(1'b1, 16'h0301, 8'h00);

        // Reset in the middle of a read: no rdy, outputs cleared
        tick();
        req_a  = 1'b1;
        addr_a = 16'h0040;
        tick();
        tick();
        reset_n = 1'b0;
        req_a   = 1'b0;
        #1;
        chk("midrd_rst_rdy_a", rdy_a, 0);
        chk("midrd_rst_mem_addr", mem_addr, 0);
        chk("midrd_rst_rd_data", rd_data, 0);
        chk("midrd_rst_core_reset", core_reset, 1);
        tick();
        tick();
        reset_n = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!core_reset) begin
                done = 1'b1;
                break;
            end
        end
        chk("midrd_core_reset_released", done, 1);
        do_read(1'b0, 16'h0040, 8'h5C);

        repeat (5) tick();
        chk("rd_queue_empty", rd_q.size(), 0);
        chk("wr_queue_empty", wr_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_load_arbiter.md
ROM_LOAD_ARBITER -- requirements
Module: rom_load_arbiter

Interface
REQ-001 Parameter AW, default 16, memory address width in bits (memory depth 2**AW bytes).
REQ-002 Parameter HOLD_CYCLES, default 16, clk_sys cycles core_reset stays high after download ends.
REQ-003 clk_sys  in  1  single clock; all logic on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 dl_active  in  1  ROM download in progress (ioctl_download).
REQ-006 dl_wr  in  1  one-cycle download byte strobe.
REQ-007 dl_addr  in  25  download byte address.
REQ-008 dl_data  in  8  download byte.
REQ-009 req_a / req_b  in  1 each  read request, main CPU (a) / sound CPU (b).
REQ-010 addr_a / addr_b  in  AW each  read address.
REQ-011 rdy_a / rdy_b  out  1 each  one-cycle read-complete pulse.
REQ-012 rd_data  out  8  read data, valid while rdy_a or rdy_b is high.
REQ-013 mem_addr  out  AW, mem_we  out  1, mem_wdata  out  8, mem_rdata  in  8  single-port sync RAM, 2-cycle read latency.
REQ-014 core_reset  out  1  reset to the game core.
REQ-015 dl_overflow  out  1  sticky: download byte lost.

Function
REQ-016 FSM states: IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_DONE.
REQ-017 dl_wr with dl_addr < 2**AW loads a one-entry write buffer (addr, data, valid); dl_addr >= 2**AW is discarded silently.
REQ-018 dl_wr while the buffer is valid and not being drained that cycle sets dl_overflow; the new byte is dropped, buffered byte kept.
REQ-019 Grant priority in IDLE: valid write buffer > reads; between req_a and req_b, round-robin, starting with a after reset, alternating only when both request.
REQ-020 WRITE: mem_we=1 for exactly one cycle with buffered addr/data; buffer cleared that cycle; next state IDLE.
REQ-021 Reads are not granted while dl_active=1 or core_reset=1.
REQ-022 Read timing: req sampled in IDLE at edge t; mem_addr=addr at t+1 (RD_ISSUE); RD_WAIT at t+2; rd_data captured from mem_rdata and rdy pulses high one cycle at t+3 (RD_DONE); IDLE at t+4.
REQ-023 Requester holds req and addr until rdy; req still high in the cycle after RD_DONE is a new request.
REQ-024 A write arriving during a read is buffered and served in the next IDLE, before any read.
REQ-025 mem_we=0 in every state except WRITE; mem_addr holds its last value otherwise.
REQ-026 core_reset=1 while dl_active=1 and for exactly HOLD_CYCLES cycles after dl_active falls; a new rise of dl_active during the hold restarts it.
REQ-027 dl_overflow clears only on reset or on a rising edge of dl_active.

Reset
REQ-028 reset_n low asynchronously forces: state IDLE, buffer invalid, rdy_a=rdy_b=0, mem_we=0, mem_addr=0, mem_wdata=0, rd_data=0, dl_overflow=0, round-robin pointer to a, core_reset=1, hold counter=HOLD_CYCLES.
REQ-029 After reset_n rises, core_reset falls HOLD_CYCLES cycles later if dl_active=0.
REQ-030 Reset mid-read aborts it with no rdy pulse.

Structure
REQ-031 Package rom_arb_pkg holds the state enum, READ_LATENCY=2 and default AW/HOLD_CYCLES.
REQ-032 Hold counter plus dl_active edge detect is sub-module rst_hold_timer; rest is one module.

Verification
REQ-033 Reset release, dl_active=0, HOLD_CYCLES=16 -> core_reset falls exactly 16 cycles after reset_n rises.
REQ-034 dl_wr addr 0x0123 data 0xA5 -> one mem_we cycle with mem_addr=0x0123, mem_wdata=0xA5; dl_addr 0x10000 -> no mem_we.
REQ-035 dl_wr on two consecutive cycles while a read is in RD_WAIT -> second byte dropped, dl_overflow=1, first byte written after read.
REQ-036 req_a=1 addr 0x0040, memory holds 0x5C -> rdy_a at t+3 with rd_data=0x5C, rdy_b=0.
REQ-037 req_a and req_b held high continuously -> grants alternate a, b, a, b, one rdy every 4 cycles.
REQ-038 dl_active pulsed again 5 cycles into hold -> core_reset stays high until 16 cycles after second fall.
